elm_prod_accum: RTL and testbench

- Downstream consumer of the 16x16 approximate multiplier's signed 32-bit product `p`.
- Accumulates a frame of products into a wide signed accumulator, for dot-product and FIR use of the approximate multiplier.
- Presents each finished frame sum on a valid/ready output stream.
- Upstream feeds one product per accepted beat over a valid/ready input stream, with an optional early-end marker.

---
 rtl/elm_prod_accum.sv | 154 +++++++++++++++
 tb/tb_elm_prod_accum.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/elm_prod_accum.sv
// elm_prod_accum: frame accumulator for the signed 32-bit products of the
// approximate multiplier. Sums up to LEN products per frame into a signed
// ACC_W accumulator (wrapping or saturating) and presents each frame sum on
// a valid/ready output stream together with its element count and an
// overflow flag.
module elm_prod_accum #(
  parameter int unsigned LEN   = 8,
  parameter int unsigned ACC_W = 40,
  parameter int unsigned SAT   = 0,
  parameter int unsigned CNT_W = $clog2(LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_p,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [ACC_W-1:0] SUM_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SUM_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_LEN = CNT_W'(LEN);

  logic [1:0]       state_q,     state_d;
  logic [ACC_W-1:0] acc_q,       acc_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic             ovf_q,       ovf_d;
  logic             out_valid_q, out_valid_d;
  logic [ACC_W-1:0] out_sum_q,   out_sum_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic             out_ovf_q,   out_ovf_d;

  logic [ACC_W-1:0] p_ext;
  logic [ACC_W-1:0] sum_raw;
  logic [ACC_W-1:0] sum_res;
  logic             add_ovf;
  logic [CNT_W-1:0] cnt_inc;
  logic             accept;
  logic             close;

  // Sign-extend the product to accumulator width.
  assign p_ext = ACC_W'($signed(in_p));

  // Ready depends on state and the abort controls only, never on in_valid.
  assign in_ready = (state_q != ST_DRAIN) & ~rst & ~flush;
  assign accept   = in_valid & in_ready;

  // Adder with signed-overflow detect, optional clamp, and frame-close decode.
  always_comb begin
    sum_raw = acc_q + p_ext;
    add_ovf = (acc_q[ACC_W-1] == p_ext[ACC_W-1]) &&
              (sum_raw[ACC_W-1] != acc_q[ACC_W-1]);
    sum_res = sum_raw;
    if ((SAT != 0) && add_ovf) begin
      sum_res = acc_q[ACC_W-1] ? SUM_MIN : SUM_MAX;
    end
    cnt_inc = cnt_q + CNT_W'(1);
    close   = in_last | (cnt_inc == CNT_LEN);
  end

  // Next-state and next-output logic; flush discards the open or held frame.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;

    if (flush) begin
      state_d     = ST_IDLE;
      acc_d       = '0;
      cnt_d       = '0;
      ovf_d       = 1'b0;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_ACCUM: begin
          if (accept) begin
            if (close) begin
              out_sum_d   = sum_res;
              out_count_d = cnt_inc;
              out_ovf_d   = ovf_q | add_ovf;
              out_valid_d = 1'b1;
              state_d     = ST_DRAIN;
            end else begin
              acc_d   = sum_res;
              cnt_d   = cnt_inc;
              ovf_d   = ovf_q | add_ovf;
              state_d = ST_ACCUM;
            end
          end
        end
        ST_DRAIN: begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            acc_d       = '0;
            cnt_d       = '0;
            ovf_d       = 1'b0;
            state_d     = ST_IDLE;
          end
        end
        default: begin
          state_d     = ST_IDLE;
          acc_d       = '0;
          cnt_d       = '0;
          ovf_d       = 1'b0;
          out_valid_d = 1'b0;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_count = out_count_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_elm_prod_accum.sv
// Bench for elm_prod_accum: four parameterisations driven side by side,
// directed scenarios followed by random traffic, all checked against a
// frame-level arithmetic model.
module tb_elm_prod_accum;

  logic clk;
  logic rst;
  logic flush;
  logic [3:0]  iv, il, ordy, ov, oo, ir;
  logic [31:0] ip [4];

  logic [39:0] os0, os1;
  logic [31:0] os2, os3;
  logic [2:0]  oc0;
  logic [3:0]  oc1;
  logic [1:0]  oc2, oc3;

  logic [63:0] osum [4];
  logic [7:0]  ocnt [4];

  int checks;
  int failures;

  // Model parameters per instance.
  int m_len [4];
  int m_w   [4];
  bit m_sat [4];

  // Model state per instance.
  bit     m_drain [4];
  longint m_acc   [4];
  int     m_cnt   [4];
  bit     m_ovf   [4];
  bit     m_valid [4];
  longint m_sum   [4];
  int     m_count [4];
  bit     m_oovf  [4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  elm_prod_accum #(.LEN(4), .ACC_W(40), .SAT(0)) u0 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(iv[0]), .in_ready(ir[0]),
    .in_p(ip[0]), .in_last(il[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
    .out_sum(os0), .out_count(oc0), .out_ovf(oo[0]));

  elm_prod_accum #(.LEN(8), .ACC_W(40), .SAT(0)) u1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(iv[1]), .in_ready(ir[1]),
    .in_p(ip[1]), .in_last(il[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
    .out_sum(os1), .out_count(oc1), .out_ovf(oo[1]));

  elm_prod_accum #(.LEN(2), .ACC_W(32), .SAT(1)) u2 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(iv[2]), .in_ready(ir[2]),
    .in_p(ip[2]), .in_last(il[2]), .out_valid(ov[2]), .out_ready(ordy[2]),
    .out_sum(os2), .out_count(oc2), .out_ovf(oo[2]));

  elm_prod_accum #(.LEN(2), .ACC_W(32), .SAT(0)) u3 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(iv[3]), .in_ready(ir[3]),
    .in_p(ip[3]), .in_last(il[3]), .out_valid(ov[3]), .out_ready(ordy[3]),
    .out_sum(os3), .out_count(oc3), .out_ovf(oo[3]));

  assign osum[0] = {{24{os0[39]}}, os0};
  assign osum[1] = {{24{os1[39]}}, os1};
  assign osum[2] = {{32{os2[31]}}, os2};
  assign osum[3] = {{32{os3[31]}}, os3};
  assign ocnt[0] = {5'd0, oc0};
  assign ocnt[1] = {4'd0, oc1};
  assign ocnt[2] = {6'd0, oc2};
  assign ocnt[3] = {6'd0, oc3};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reinterpret the low w bits of s as a signed w-bit number.
  function automatic longint wrap_to(input longint s, input int w);
    int sh;
    sh = 64 - w;
    return (s <<< sh) >>> sh;
  endfunction

  function automatic bit mdl_ready(input int i);
    return !m_drain[i] && !rst && !flush;
  endfunction

  // One clock of the frame model for instance i, using the inputs at the edge.
  task automatic mdl_update(input int i);
    longint p, s, mx, mn, res;
    bit     o;
    int     n;
    if (rst) begin
      m_drain[i] = 0; m_acc[i] = 0; m_cnt[i] = 0; m_ovf[i] = 0;
      m_valid[i] = 0; m_sum[i] = 0; m_count[i] = 0; m_oovf[i] = 0;
    end else if (flush) begin
      m_drain[i] = 0; m_acc[i] = 0; m_cnt[i] = 0; m_ovf[i] = 0; m_valid[i] = 0;
    end else if (m_drain[i]) begin
      if (ordy[i]) begin
        m_drain[i] = 0; m_acc[i] = 0; m_cnt[i] = 0; m_ovf[i] = 0; m_valid[i] = 0;
      end
    end else if (iv[i]) begin
      p   = longint'($signed(ip[i]));
      s   = m_acc[i] + p;
      mx  = (longint'(1) <<< (m_w[i] - 1)) - 1;
      mn  = -mx - 1;
      o   = (s > mx) || (s < mn);
      res = s;
      if (o) res = m_sat[i] ? ((s > mx) ? mx : mn) : wrap_to(s, m_w[i]);
      n = m_cnt[i] + 1;
      if (il[i] || n == m_len[i]) begin
        m_sum[i] = res; m_count[i] = n; m_oovf[i] = m_ovf[i] | o;
        m_drain[i] = 1; m_valid[i] = 1;
      end else begin
        m_acc[i] = res; m_cnt[i] = n; m_ovf[i] = m_ovf[i] | o;
      end
    end
  endtask

  // Apply the current inputs for one clock and compare all instances.
  task automatic step();
    #1;
    for (int i = 0; i < 4; i++)
      chk($sformatf("u%0d.in_ready", i), 64'(ir[i]), 64'(mdl_ready(i)));
    for (int i = 0; i < 4; i++) mdl_update(i);
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("u%0d.out_valid", i), 64'(ov[i]), 64'(m_valid[i]));
      if (m_valid[i]) begin
        chk($sformatf("u%0d.out_sum", i), osum[i], 64'(m_sum[i]));
        chk($sformatf("u%0d.out_count", i), 64'(ocnt[i]), 64'(m_count[i]));
        chk($sformatf("u%0d.out_ovf", i), 64'(oo[i]), 64'(m_oovf[i]));
      end
    end
  endtask

  task automatic idle_all();
    iv = '0; il = '0;
    for (int i = 0; i < 4; i++) ip[i] = '0;
  endtask

  initial begin
    checks = 0; failures = 0;
    m_len = '{4, 8, 2, 2};
    m_w   = '{40, 40, 32, 32};
    m_sat = '{0, 0, 1, 0};
    for (int i = 0; i < 4; i++) begin
      m_drain[i] = 0; m_acc[i] = 0; m_cnt[i] = 0; m_ovf[i] = 0;
      m_valid[i] = 0; m_sum[i] = 0; m_count[i] = 0; m_oovf[i] = 0;
    end
    rst = 1'b1; flush = 1'b0; ordy = '0;
    idle_all();

    // Reset state.
    step(); step();
    chk("rst.out_sum", osum[0], 64'd0);
    chk("rst.out_count", 64'(ocnt[0]), 64'd0);
    rst = 1'b0;

    // 1: four products, frame closes on LEN.
    ordy[0] = 1'b1; iv[0] = 1'b1;
    ip[0] = 32'd100;  step();
    ip[0] = -32'sd50; step();
    ip[0] = 32'd7;    step();
    ip[0] = 32'd1;    step();
    chk("t1.out_valid", 64'(ov[0]), 64'd1);
    chk("t1.out_sum", osum[0], 64'd58);
    chk("t1.out_count", 64'(ocnt[0]), 64'd4);
    chk("t1.out_ovf", 64'(oo[0]), 64'd0);
    iv[0] = 1'b0; step();
    chk("t1.pulse", 64'(ov[0]), 64'd0);

    // 2: carry past 32 bits with early in_last.
    ordy[1] = 1'b1; iv[1] = 1'b1;
    ip[1] = 32'h7FFF_FFFF; step();
    ip[1] = 32'h0000_0001; il[1] = 1'b1; step();
    chk("t2.out_sum", osum[1], 64'h0000_0000_8000_0000);
    chk("t2.out_count", 64'(ocnt[1]), 64'd2);
    chk("t2.out_ovf", 64'(oo[1]), 64'd0);
    idle_all(); step();

    // 3: backpressure holds the result and blocks input.
    ordy[0] = 1'b0; iv[0] = 1'b1; ip[0] = 32'd3; il[0] = 1'b1; step();
    il[0] = 1'b0; ip[0] = 32'd9;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t3.hold_valid", 64'(ov[0]), 64'd1);
      chk("t3.hold_sum", osum[0], 64'd3);
      chk("t3.in_ready", 64'(ir[0]), 64'd0);
    end
    ordy[0] = 1'b1; step();
    step();
    ip[0] = 32'd1; il[0] = 1'b1; step();
    chk("t3.next_sum", osum[0], 64'd10);
    chk("t3.next_count", 64'(ocnt[0]), 64'd2);
    idle_all(); step();

    // 4: saturating vs wrapping overflow, then a clean frame.
    ordy[2] = 1'b1; ordy[3] = 1'b1; iv[2] = 1'b1; iv[3] = 1'b1;
    ip[2] = 32'h7FFF_FFFF; ip[3] = 32'h7FFF_FFFF; step(); step();
    chk("t4.sat_sum", osum[2], 64'h0000_0000_7FFF_FFFF);
    chk("t4.sat_ovf", 64'(oo[2]), 64'd1);
    chk("t4.wrap_sum", osum[3], 64'hFFFF_FFFF_FFFF_FFFE);
    chk("t4.wrap_ovf", 64'(oo[3]), 64'd1);
    idle_all(); step();
    iv[2] = 1'b1; iv[3] = 1'b1;
    ip[2] = 32'd1; ip[3] = 32'd1; step();
    ip[2] = 32'd2; ip[3] = 32'd2; step();
    chk("t4.clean_sum", osum[2], 64'd3);
    chk("t4.clean_ovf", 64'(oo[2]), 64'd0);
    idle_all(); step();

    // 5: flush drops the open frame and the same-cycle beat.
    iv[0] = 1'b1;
    ip[0] = 32'd5; step();
    ip[0] = 32'd6; step();
    flush = 1'b1; ip[0] = 32'd7; #1;
    chk("t5.flush_ready", 64'(ir[0]), 64'd0);
    step();
    flush = 1'b0; iv[0] = 1'b0; step();
    iv[0] = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      ip[0] = 32'(k); step();
    end
    chk("t5.out_sum", osum[0], 64'd10);
    chk("t5.out_count", 64'(ocnt[0]), 64'd4);
    idle_all(); step();

    // 6: reset while a result is held.
    ordy[0] = 1'b0; iv[0] = 1'b1;
    ip[0] = 32'd100;  step();
    ip[0] = -32'sd50; step();
    ip[0] = 32'd7;    step();
    ip[0] = 32'd1;    step();
    chk("t6.held_sum", osum[0], 64'd58);
    iv[0] = 1'b0; rst = 1'b1; step();
    chk("t6.out_valid", 64'(ov[0]), 64'd0);
    chk("t6.out_sum", osum[0], 64'd0);
    chk("t6.out_count", 64'(ocnt[0]), 64'd0);
    rst = 1'b0; #1;
    chk("t6.in_ready", 64'(ir[0]), 64'd1);
    ordy[0] = 1'b1; iv[0] = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      ip[0] = 32'(k); step();
    end
    chk("t6.next_sum", osum[0], 64'd14);
    idle_all(); step();

    // Random traffic on all instances.
    for (int c = 0; c < 3000; c++) begin
      rst   = ($urandom_range(0, 199) == 0);
      flush = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < 4; i++) begin
        iv[i]   = ($urandom_range(0, 3) != 0);
        il[i]   = ($urandom_range(0, 5) == 0);
        ordy[i] = ($urandom_range(0, 2) != 0);
        case ($urandom_range(0, 3))
          0:       ip[i] = $urandom;
          1:       ip[i] = 32'h7FFF_FFFF;
          2:       ip[i] = 32'h8000_0000;
          default: ip[i] = 32'($urandom_range(0, 255)) - 32'd128;
        endcase
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
